// File: rtl/riscv_pkg.sv
// Shared pipeline-control types: hazard FSM states, trap vector and the bundled stall/flush strobes.
// Pure declarations, no logic.
package riscv_pkg;

  typedef enum logic [1:0] {
    HZ_RUN,
    HZ_MEM_WAIT,
    HZ_TRAP
  } hazard_state_e;

  localparam logic [31:0] TRAP_PC_DEFAULT = 32'h0000_0100;

  // One field per pipeline-register control input.
  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic id_ex_stall;
    logic ex_mem_stall;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic mem_wb_flush;
  } hazard_ctrl_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use compare between the ID source operands and a load sitting in EX.
// Purely combinational, zero latency, no flow control.
module hazard_detect (
  input  logic       ex_valid_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_addr_i,
  input  logic [4:0] id_rs1_addr_i,
  input  logic [4:0] id_rs2_addr_i,
  input  logic       id_uses_rs1_i,
  input  logic       id_uses_rs2_i,
  output logic       load_use_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_uses_rs1_i & (id_rs1_addr_i == ex_rd_addr_i);
  assign rs2_hit = id_uses_rs2_i & (id_rs2_addr_i == ex_rd_addr_i);

  // x0 is never written, so a load targeting it cannot create a dependency.
  assign load_use_o = ex_valid_i & ex_mem_read_i & (ex_rd_addr_i != 5'd0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: stall/flush strobes are combinational from registered FSM state plus inputs;
// redirects land at the next edge; memory wait states stall everything upstream of MEM and time out into a trap.
module pipeline_hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter logic [31:0] TRAP_PC     = TRAP_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target_pc,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        id_ex_stall,
  output logic        ex_mem_stall,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        mem_wb_flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        mem_timeout_err,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  // Number of stalled cycles (counting the current one) that triggers the trap.
  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);

  hazard_state_e state_q, state_d;
  logic [7:0]    wait_cnt_q, wait_cnt_d;
  logic          err_q, err_d;
  logic [31:0]   stall_cnt_q, stall_cnt_d;
  logic [31:0]   flush_cnt_q, flush_cnt_d;

  logic          mem_busy;
  logic          load_use;
  hazard_ctrl_t  ctrl;
  logic          redir_vld;
  logic [31:0]   redir_pc;

  assign mem_busy = dmem_req & ~dmem_ready;

  hazard_detect u_hazard_detect (
    .ex_valid_i    (ex_valid),
    .ex_mem_read_i (ex_mem_read),
    .ex_rd_addr_i  (ex_rd_addr),
    .id_rs1_addr_i (id_rs1_addr),
    .id_rs2_addr_i (id_rs2_addr),
    .id_uses_rs1_i (id_uses_rs1),
    .id_uses_rs2_i (id_uses_rs2),
    .load_use_o    (load_use)
  );

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    ctrl       = '0;
    redir_vld  = 1'b0;
    redir_pc   = '0;

    unique case (state_q)
      HZ_RUN, HZ_MEM_WAIT: begin
        if (mem_busy) begin
          // Freeze everything up to MEM and bubble WB; a taken branch in EX waits its turn.
          ctrl.pc_stall     = 1'b1;
          ctrl.if_id_stall  = 1'b1;
          ctrl.id_ex_stall  = 1'b1;
          ctrl.ex_mem_stall = 1'b1;
          ctrl.mem_wb_flush = 1'b1;
          wait_cnt_d = (state_q == HZ_RUN) ? 8'd1 : (wait_cnt_q + 8'd1);
          if (wait_cnt_d >= WAIT_LIMIT) begin
            state_d = HZ_TRAP;
            err_d   = 1'b1;
          end else begin
            state_d = HZ_MEM_WAIT;
          end
        end else begin
          state_d    = HZ_RUN;
          wait_cnt_d = 8'd0;
          if (ex_redirect & ex_valid) begin
            redir_vld        = 1'b1;
            redir_pc         = ex_target_pc;
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
          end else if (load_use) begin
            ctrl.pc_stall    = 1'b1;
            ctrl.if_id_stall = 1'b1;
            ctrl.id_ex_flush = 1'b1;
          end
        end
      end
      HZ_TRAP: begin
        ctrl.if_id_flush  = 1'b1;
        ctrl.id_ex_flush  = 1'b1;
        ctrl.ex_mem_flush = 1'b1;
        ctrl.mem_wb_flush = 1'b1;
        redir_vld         = 1'b1;
        redir_pc          = TRAP_PC;
        state_d           = HZ_RUN;
        wait_cnt_d        = 8'd0;
      end
      default: begin
        state_d    = HZ_RUN;
        wait_cnt_d = 8'd0;
      end
    endcase

    if (reset) begin
      ctrl      = '0;
      redir_vld = 1'b0;
      redir_pc  = '0;
    end
  end

  assign stall_cnt_d = stall_cnt_q + {31'd0, ctrl.pc_stall};
  assign flush_cnt_d = flush_cnt_q + {31'd0, ctrl.if_id_flush};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HZ_RUN;
      wait_cnt_q  <= 8'd0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign pc_stall        = ctrl.pc_stall;
  assign if_id_stall     = ctrl.if_id_stall;
  assign id_ex_stall     = ctrl.id_ex_stall;
  assign ex_mem_stall    = ctrl.ex_mem_stall;
  assign if_id_flush     = ctrl.if_id_flush;
  assign id_ex_flush     = ctrl.id_ex_flush;
  assign ex_mem_flush    = ctrl.ex_mem_flush;
  assign mem_wb_flush    = ctrl.mem_wb_flush;
  assign redirect_valid  = redir_vld;
  assign redirect_pc     = redir_pc;
  assign mem_timeout_err = err_q;
  assign stall_cnt       = stall_cnt_q;
  assign flush_cnt       = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: instance a uses the default timeout, instance b a timeout of 4.
// Strobe vectors are {pc_s, if_id_s, id_ex_s, ex_mem_s, if_id_f, id_ex_f, ex_mem_f, mem_wb_f}.
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic        id_uses_rs1, id_uses_rs2, ex_valid, ex_mem_read, ex_redirect;
  logic [31:0] ex_target_pc;
  logic        dmem_req, dmem_ready;

  logic        a_pcs, a_ifs, a_ids, a_exs, a_iff, a_idf, a_exf, a_wbf, a_rv, a_err;
  logic [31:0] a_rpc, a_scnt, a_fcnt;
  logic        b_pcs, b_ifs, b_ids, b_exs, b_iff, b_idf, b_exf, b_wbf, b_rv, b_err;
  logic [31:0] b_rpc, b_scnt, b_fcnt;
  logic [7:0]  a_strb, b_strb;

  int total;
  int bad;

  assign a_strb = {a_pcs, a_ifs, a_ids, a_exs, a_iff, a_idf, a_exf, a_wbf};
  assign b_strb = {b_pcs, b_ifs, b_ids, b_exs, b_iff, b_idf, b_exf, b_wbf};

  pipeline_hazard_ctrl dut_a (
    .clk(clk), .reset(reset),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
    .ex_redirect(ex_redirect), .ex_target_pc(ex_target_pc),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_stall(a_pcs), .if_id_stall(a_ifs), .id_ex_stall(a_ids), .ex_mem_stall(a_exs),
    .if_id_flush(a_iff), .id_ex_flush(a_idf), .ex_mem_flush(a_exf), .mem_wb_flush(a_wbf),
    .redirect_valid(a_rv), .redirect_pc(a_rpc), .mem_timeout_err(a_err),
    .stall_cnt(a_scnt), .flush_cnt(a_fcnt)
  );

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4)) dut_b (
    .clk(clk), .reset(reset),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
    .ex_redirect(ex_redirect), .ex_target_pc(ex_target_pc),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_stall(b_pcs), .if_id_stall(b_ifs), .id_ex_stall(b_ids), .ex_mem_stall(b_exs),
    .if_id_flush(b_iff), .id_ex_flush(b_idf), .ex_mem_flush(b_exf), .mem_wb_flush(b_wbf),
    .redirect_valid(b_rv), .redirect_pc(b_rpc), .mem_timeout_err(b_err),
    .stall_cnt(b_scnt), .flush_cnt(b_fcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; ex_rd_addr = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_redirect = 1'b0;
    ex_target_pc = 32'd0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    // Hostile inputs while reset is held: every output must stay inactive.
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd_addr = 5'd5;
    id_rs1_addr = 5'd5; id_uses_rs1 = 1'b1;
    ex_redirect = 1'b1; ex_target_pc = 32'h0000_4444;
    dmem_req = 1'b1; dmem_ready = 1'b0;
    #2;
    if (a_strb !== 8'h00) begin bad++; $display("FAIL rst_strobes got=%b want=%b", a_strb, 8'h00); end
    total++;
    if (a_rv !== 1'b0 || a_rpc !== 32'd0) begin bad++; $display("FAIL rst_redirect got=%b/%h want=0/0", a_rv, a_rpc); end
    total++;
    next_cycle();
    if (a_scnt !== 32'd0 || a_fcnt !== 32'd0) begin bad++; $display("FAIL rst_counters got=%0d/%0d want=0/0", a_scnt, a_fcnt); end
    total++;
    if (a_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", a_err); end
    total++;
    reset = 1'b0;
    idle();
    #2;
    if (a_strb !== 8'h00 || a_rv !== 1'b0) begin bad++; $display("FAIL rst_idle got=%b/%b want=00000000/0", a_strb, a_rv); end
    total++;
    next_cycle();
  endtask

  task automatic test_load_use();
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd_addr = 5'd5;
    id_rs1_addr = 5'd5; id_uses_rs1 = 1'b1;
    #2;
    if (a_strb !== 8'b1100_0100) begin bad++; $display("FAIL lu_rs1_strobes got=%b want=%b", a_strb, 8'b1100_0100); end
    total++;
    if (a_rv !== 1'b0) begin bad++; $display("FAIL lu_rs1_redirect got=%b want=0", a_rv); end
    total++;
    next_cycle();
    if (a_scnt !== 32'd1) begin bad++; $display("FAIL lu_stall_cnt got=%0d want=1", a_scnt); end
    total++;
    idle();
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd_addr = 5'd17;
    id_rs1_addr = 5'd3; id_uses_rs1 = 1'b1; id_rs2_addr = 5'd17; id_uses_rs2 = 1'b1;
    #2;
    if (a_strb !== 8'b1100_0100) begin bad++; $display("FAIL lu_rs2_strobes got=%b want=%b", a_strb, 8'b1100_0100); end
    total++;
    next_cycle();
    // Register matches but the operand is not read: no hazard.
    id_uses_rs2 = 1'b0;
    #2;
    if (a_strb !== 8'h00) begin bad++; $display("FAIL lu_unused_strobes got=%b want=%b", a_strb, 8'h00); end
    total++;
    next_cycle();
    if (a_scnt !== 32'd2 || a_fcnt !== 32'd0) begin bad++; $display("FAIL lu_counters got=%0d/%0d want=2/0", a_scnt, a_fcnt); end
    total++;
    idle();
  endtask

  task automatic test_x0_load();
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd_addr = 5'd0;
    id_rs1_addr = 5'd0; id_uses_rs1 = 1'b1;
    #2;
    if (a_strb !== 8'h00) begin bad++; $display("FAIL x0_strobes got=%b want=%b", a_strb, 8'h00); end
    total++;
    next_cycle();
    if (a_scnt !== 32'd2 || a_fcnt !== 32'd0) begin bad++; $display("FAIL x0_counters got=%0d/%0d want=2/0", a_scnt, a_fcnt); end
    total++;
    idle();
  endtask

  task automatic test_redirect_priority();
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd_addr = 5'd5;
    id_rs1_addr = 5'd5; id_uses_rs1 = 1'b1;
    ex_redirect = 1'b1; ex_target_pc = 32'h0000_2000;
    #2;
    if (a_strb !== 8'b0000_1100) begin bad++; $display("FAIL redir_strobes got=%b want=%b", a_strb, 8'b0000_1100); end
    total++;
    if (a_rv !== 1'b1 || a_rpc !== 32'h0000_2000) begin bad++; $display("FAIL redir_pc got=%b/%h want=1/00002000", a_rv, a_rpc); end
    total++;
    next_cycle();
    if (a_fcnt !== 32'd1 || a_scnt !== 32'd2) begin bad++; $display("FAIL redir_counters got=%0d/%0d want=2/1", a_scnt, a_fcnt); end
    total++;
    idle();
    ex_redirect = 1'b1; ex_target_pc = 32'h0000_2000;
    #2;
    if (a_rv !== 1'b0 || a_strb !== 8'h00) begin bad++; $display("FAIL redir_invalid got=%b/%b want=0/00000000", a_rv, a_strb); end
    total++;
    next_cycle();
    idle();
  endtask

  task automatic test_back_to_back();
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd_addr = 5'd9;
    id_rs2_addr = 5'd9; id_uses_rs2 = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #2;
      if (a_strb !== 8'b1100_0100) begin bad++; $display("FAIL b2b_lu%0d got=%b want=%b", c, a_strb, 8'b1100_0100); end
      total++;
      next_cycle();
    end
    ex_redirect = 1'b1; ex_target_pc = 32'h0000_0abc;
    #2;
    if (a_strb !== 8'b0000_1100 || a_rpc !== 32'h0000_0abc) begin bad++; $display("FAIL b2b_redir got=%b/%h want=00001100/00000abc", a_strb, a_rpc); end
    total++;
    next_cycle();
    if (a_scnt !== 32'd4 || a_fcnt !== 32'd2) begin bad++; $display("FAIL b2b_counters got=%0d/%0d want=4/2", a_scnt, a_fcnt); end
    total++;
    idle();
  endtask

  task automatic test_mem_wait();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    ex_valid = 1'b1; ex_redirect = 1'b1; ex_target_pc = 32'h0000_3000;
    for (int c = 1; c <= 3; c++) begin
      #2;
      if (a_strb !== 8'b1111_0001 || a_rv !== 1'b0) begin bad++; $display("FAIL mw_cycle%0d got=%b/%b want=11110001/0", c, a_strb, a_rv); end
      total++;
      next_cycle();
    end
    dmem_ready = 1'b1;
    #2;
    if (a_strb !== 8'b0000_1100) begin bad++; $display("FAIL mw_release_strobes got=%b want=%b", a_strb, 8'b0000_1100); end
    total++;
    if (a_rv !== 1'b1 || a_rpc !== 32'h0000_3000) begin bad++; $display("FAIL mw_release_redir got=%b/%h want=1/00003000", a_rv, a_rpc); end
    total++;
    next_cycle();
    if (a_scnt !== 32'd7 || a_fcnt !== 32'd3) begin bad++; $display("FAIL mw_counters got=%0d/%0d want=7/3", a_scnt, a_fcnt); end
    total++;
    idle();
    #2;
    if (a_strb !== 8'h00) begin bad++; $display("FAIL mw_after got=%b want=%b", a_strb, 8'h00); end
    total++;
    next_cycle();
  endtask

  task automatic test_timeout();
    reset = 1'b1;
    idle();
    next_cycle();
    reset = 1'b0;
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      #2;
      if (b_strb !== 8'b1111_0001 || b_err !== 1'b0) begin bad++; $display("FAIL to_wait%0d got=%b/%b want=11110001/0", c, b_strb, b_err); end
      total++;
      next_cycle();
    end
    #2;
    if (b_strb !== 8'b0000_1111) begin bad++; $display("FAIL to_trap_strobes got=%b want=%b", b_strb, 8'b0000_1111); end
    total++;
    if (b_rv !== 1'b1 || b_rpc !== 32'h0000_0100) begin bad++; $display("FAIL to_trap_redir got=%b/%h want=1/00000100", b_rv, b_rpc); end
    total++;
    if (b_err !== 1'b1) begin bad++; $display("FAIL to_trap_err got=%b want=1", b_err); end
    total++;
    next_cycle();
    // Back in RUN with memory still busy: a fresh wait begins.
    #2;
    if (b_strb !== 8'b1111_0001 || b_rv !== 1'b0 || b_err !== 1'b1) begin bad++; $display("FAIL to_post got=%b/%b/%b want=11110001/0/1", b_strb, b_rv, b_err); end
    total++;
    next_cycle();
    dmem_req = 1'b0;
    #2;
    if (b_strb !== 8'h00) begin bad++; $display("FAIL to_release got=%b want=%b", b_strb, 8'h00); end
    total++;
    next_cycle();
    if (b_scnt !== 32'd4 || b_fcnt !== 32'd1 || b_err !== 1'b1) begin bad++; $display("FAIL to_final got=%0d/%0d/%b want=4/1/1", b_scnt, b_fcnt, b_err); end
    total++;
    if (a_err !== 1'b0 || a_scnt !== 32'd5) begin bad++; $display("FAIL to_long_timeout got=%b/%0d want=0/5", a_err, a_scnt); end
    total++;
  endtask

  task automatic test_reset_mid_wait();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    #2;
    if (a_strb !== 8'b1111_0001) begin bad++; $display("FAIL rmw_wait1 got=%b want=%b", a_strb, 8'b1111_0001); end
    total++;
    next_cycle();
    reset = 1'b1;
    #2;
    if (a_strb !== 8'h00 || a_rv !== 1'b0) begin bad++; $display("FAIL rmw_during got=%b/%b want=00000000/0", a_strb, a_rv); end
    total++;
    next_cycle();
    if (a_scnt !== 32'd0 || a_fcnt !== 32'd0 || b_err !== 1'b0) begin bad++; $display("FAIL rmw_cleared got=%0d/%0d/%b want=0/0/0", a_scnt, a_fcnt, b_err); end
    total++;
    reset = 1'b0;
    dmem_req = 1'b0;
    #2;
    if (a_strb !== 8'h00 || a_rv !== 1'b0) begin bad++; $display("FAIL rmw_after got=%b/%b want=00000000/0", a_strb, a_rv); end
    total++;
    next_cycle();
    if (a_scnt !== 32'd0) begin bad++; $display("FAIL rmw_stall_cnt got=%0d want=0", a_scnt); end
    total++;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle();
    reset = 1'b1;
    next_cycle();
    test_reset();
    test_load_use();
    test_x0_load();
    test_redirect_priority();
    test_back_to_back();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
